round_robin_arbiter: RTL and testbench

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

---
 rtl/arbiter_defs.sv | 14 +
 rtl/rr_priority_picker.sv | 27 ++
 rtl/round_robin_arbiter.sv | 101 ++++++++++
 tb/tb_round_robin_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_defs.sv
// Shared definitions for the 4-way round-robin arbiter: state encodings,
// requester geometry and the default grant hold limit.
package arbiter_defs;

    localparam int unsigned NUM_REQ          = 4;
    localparam int unsigned IDX_W            = 2;
    localparam int unsigned MAX_HOLD_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating-priority winner select: first asserted request scanning
// ptr+1, ptr+2, ptr+3, ptr (mod 4). Purely combinational.
module rr_priority_picker
    import arbiter_defs::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        winner  = ptr;
        any_req = 1'b0;
        idx     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!any_req && req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter for four requesters driving a 2-to-4 decoder, with
// break-before-make between grants and a forced release after MAX_HOLD cycles.
module round_robin_arbiter
    import arbiter_defs::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic               addr0,
    output logic               addr1,
    output logic               enable,
    output logic               timeout
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic             enable_q, enable_d;
    logic             timeout_q, timeout_d;

    logic [IDX_W-1:0]  winner;
    logic              any_req;
    logic [HOLD_W-1:0] hold_inc;
    logic              hold_hit;
    logic              owner_req;

    rr_priority_picker u_picker (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    assign addr0   = addr_q[0];
    assign addr1   = addr_q[1];
    assign enable  = enable_q;
    assign timeout = timeout_q;

    // ptr resets to 3 so that index 0 is scanned first after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            addr_q    <= '0;
            hold_q    <= '0;
            enable_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            hold_q    <= hold_d;
            enable_q  <= enable_d;
            timeout_q <= timeout_d;
        end
    end

    // timeout flags only a release where the hold limit was the sole cause
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        hold_d    = hold_q;
        enable_d  = 1'b0;
        timeout_d = 1'b0;
        hold_inc  = hold_q + HOLD_W'(1);
        hold_hit  = (hold_inc == HOLD_W'(MAX_HOLD));
        owner_req = req[addr_q];

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d  = GRANT;
                    ptr_d    = winner;
                    addr_d   = winner;
                    hold_d   = '0;
                    enable_d = 1'b1;
                end
            end
            GRANT: begin
                hold_d = hold_inc;
                if (done || !owner_req || hold_hit) begin
                    state_d   = IDLE;
                    timeout_d = hold_hit && !done && owner_req;
                end else begin
                    enable_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed and randomised checks of round_robin_arbiter against hand-computed
// expectations and a small rotating-priority reference model.
module tb_round_robin_arbiter;

    localparam int MAXH = 8;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       done;
    logic       addr0, addr1, enable, timeout;
    logic [3:0] req1;
    logic       done1;
    logic       addr0_1, addr1_1, enable_1, timeout_1;

    logic [3:0] obs;
    logic [3:0] obs1;
    logic [3:0] dec;

    int n_tests = 0;
    int n_fail  = 0;

    round_robin_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .addr0   (addr0),
        .addr1   (addr1),
        .enable  (enable),
        .timeout (timeout)
    );

    round_robin_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .req     (req1),
        .done    (done1),
        .addr0   (addr0_1),
        .addr1   (addr1_1),
        .enable  (enable_1),
        .timeout (timeout_1)
    );

    assign obs  = {timeout, enable, addr1, addr0};
    assign obs1 = {timeout_1, enable_1, addr1_1, addr0_1};
    // stand-in for the downstream structural 2-to-4 decoder
    assign dec  = enable ? (4'b0001 << {addr1, addr0}) : 4'b0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        for (int i = 1; i <= 4; i++) begin
            idx = p + 2'(i);
            if (r[idx]) return idx;
        end
        return p;
    endfunction

    initial begin
        logic [3:0] rq;
        logic       dn;
        logic [1:0] mptr;
        logic [1:0] paddr;
        logic       pen;
        logic       exp_en;
        logic       exp_to;
        int         run;

        reset = 1'b1;
        req   = 4'b1111;
        done  = 1'b0;
        req1  = 4'b0000;
        done1 = 1'b0;
        #2;
        check("reset_state", obs, 4'b0000);
        tick();
        check("reset_no_grant", obs, 4'b0000);
        tick();
        reset = 1'b0;
        check("reset_release", obs, 4'b0000);

        // all requesting, done each grant: 0,1,2,3,0 with a gap cycle between
        for (int i = 0; i < 5; i++) begin
            done = 1'b0;
            tick();
            check("rr_grant", obs, {2'b01, 2'(i % 4)});
            done = 1'b1;
            tick();
            check("rr_gap", obs, {2'b00, 2'(i % 4)});
        end
        done = 1'b0;
        req  = 4'b0000;

        // single requester 2, done three edges after the grant
        req = 4'b0100;
        tick();
        check("b_grant", obs, 4'b0110);
        tick();
        check("b_hold1", obs, 4'b0110);
        tick();
        check("b_hold2", obs, 4'b0110);
        done = 1'b1;
        tick();
        check("b_done", obs, 4'b0010);
        done = 1'b0;
        req  = 4'b0000;
        tick();
        check("b_idle_addr_held", obs, 4'b0010);

        // hold limit: eight enable cycles, one timeout pulse, regrant
        req = 4'b0001;
        tick();
        check("c_grant", obs, 4'b0100);
        for (int j = 1; j < MAXH; j++) begin
            tick();
            check("c_hold", obs, 4'b0100);
        end
        tick();
        check("c_timeout", obs, 4'b1000);
        tick();
        check("c_regrant", obs, 4'b0100);
        req = 4'b0000;
        tick();
        check("c_drop", obs, 4'b0000);

        // done coinciding with the hold limit
        req = 4'b0001;
        tick();
        check("d_grant", obs, 4'b0100);
        for (int j = 1; j < MAXH; j++) tick();
        check("d_hold_last", obs, 4'b0100);
        done = 1'b1;
        tick();
        check("d_done_at_max", obs, 4'b0000);
        done = 1'b0;
        req  = 4'b0000;
        tick();
        check("d_after", obs, 4'b0000);

        // request drop coinciding with the hold limit
        req = 4'b0001;
        tick();
        for (int j = 1; j < MAXH; j++) tick();
        check("d2_hold_last", obs, 4'b0100);
        req = 4'b0000;
        tick();
        check("d2_drop_at_max", obs, 4'b0000);

        // done while idle is ignored, and does not block a grant
        done = 1'b1;
        tick();
        check("e_idle_done", obs, 4'b0000);
        req = 4'b0010;
        tick();
        check("e_grant_despite_done", obs, 4'b0101);
        tick();
        check("e_release", obs, 4'b0001);
        done = 1'b0;
        req  = 4'b0000;

        // requester just released drops to lowest priority
        req = 4'b0011;
        tick();
        check("f_grant0", obs, 4'b0100);
        done = 1'b1;
        tick();
        check("f_rel0", obs, 4'b0000);
        done = 1'b0;
        tick();
        check("f_grant1", obs, 4'b0101);
        done = 1'b1;
        tick();
        check("f_rel1", obs, 4'b0001);
        done = 1'b0;
        req  = 4'b0000;

        // asynchronous reset in the middle of a grant
        req = 4'b0100;
        tick();
        check("g_grant", obs, 4'b0110);
        #3 reset = 1'b1;
        #1;
        check("g_async_reset", obs, 4'b0000);
        req = 4'b1000;
        tick();
        check("g_in_reset", obs, 4'b0000);
        reset = 1'b0;
        tick();
        check("g_post_reset_grant", obs, 4'b0111);
        req = 4'b0000;
        tick();
        check("g_drop", obs, 4'b0011);

        // MAX_HOLD=1 instance
        req1 = 4'b0001;
        tick();
        check("h_grant", obs1, 4'b0100);
        tick();
        check("h_timeout", obs1, 4'b1000);
        tick();
        check("h_regrant", obs1, 4'b0100);
        done1 = 1'b1;
        tick();
        check("h_done_coincide", obs1, 4'b0000);
        done1 = 1'b0;
        tick();
        check("h_grant2", obs1, 4'b0100);
        req1 = 4'b0000;
        tick();
        check("h_drop_coincide", obs1, 4'b0000);

        // random traffic against a reference model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mptr  = 2'd3;
        paddr = 2'd0;
        pen   = 1'b0;
        run   = 0;
        for (int c = 0; c < 10000; c++) begin
            rq   = 4'($urandom_range(0, 15));
            dn   = ($urandom_range(0, 3) == 0);
            req  = rq;
            done = dn;
            tick();
            check("rnd_dec_onehot0", 32'($onehot0(dec)), 1);
            if (!pen) begin
                exp_en = (rq != 4'b0000);
                check("rnd_grant", enable, exp_en);
                check("rnd_to_idle", timeout, 0);
                if (exp_en) begin
                    check("rnd_pick", {addr1, addr0}, pick(rq, mptr));
                    mptr  = pick(rq, mptr);
                    paddr = mptr;
                    run   = 1;
                end
            end else begin
                exp_en = !dn && rq[paddr] && (run < MAXH);
                exp_to = !dn && rq[paddr] && (run == MAXH);
                check("rnd_enable", enable, exp_en);
                check("rnd_timeout", timeout, exp_to);
                check("rnd_addr_hold", {addr1, addr0}, paddr);
                if (exp_en) run++;
                else run = 0;
            end
            pen = exp_en;
        end
        req  = 4'b0000;
        done = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
